pipe_skid_reg: RTL

- Parametrised successor to the fixed-width inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM).
- Carries one opaque payload bus between two pipeline stages using a valid/ready handshake.
- Has a synchronous flush (branch/trap squash) and an optional 2-entry skid buffer, so upstream ready is a registered signal.
- Stage-specific payloads are concatenated into in_data_i by the instantiating stage.

---
 rtl/pipe_skid_reg_pkg.sv | 37 +++
 rtl/pipe_skid_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers: FSM state encoding,
// default field widths and the stage payload widths built from them.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        PSR_EMPTY = 2'd0,
        PSR_BUSY  = 2'd1,
        PSR_FULL  = 2'd2
    } psr_state_e;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned PC_W       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned IMM_W      = 32;
    localparam int unsigned ID_EX_CTRL_W  = 12;
    localparam int unsigned EX_MEM_CTRL_W = 6;

    localparam int unsigned IF_ID_PAYLOAD_W  = PC_W + INST_W;
    localparam int unsigned ID_EX_PAYLOAD_W  = PC_W + (2 * REG_DATA_W) + IMM_W
                                               + REG_ADDR_W + ID_EX_CTRL_W;
    localparam int unsigned EX_MEM_PAYLOAD_W = (2 * REG_DATA_W) + REG_ADDR_W
                                               + EX_MEM_CTRL_W;

    // Number of held entries for a given state.
    function automatic logic [1:0] psr_occ(input psr_state_e state);
        logic [1:0] occ;
        case (state)
            PSR_EMPTY: occ = 2'd0;
            PSR_BUSY:  occ = 2'd1;
            PSR_FULL:  occ = 2'd2;
            default:   occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Parametrised valid/ready pipeline register with synchronous flush and an
// optional 2-entry skid buffer that makes the upstream ready a registered signal.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W       = 32,
    parameter bit                SKID_EN      = 1'b1,
    parameter logic [DATA_W-1:0] RST_VAL      = {DATA_W{1'b0}},
    parameter bit                CLR_ON_FLUSH = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    if (SKID_EN) begin : g_skid
        psr_state_e        state_r, state_fsm_s, state_nxt_s;
        logic [DATA_W-1:0] main_r, main_fsm_s, main_nxt_s;
        logic [DATA_W-1:0] skid_r, skid_fsm_s, skid_nxt_s;
        logic              ready_r;
        logic              valid_r;
        logic [1:0]        occ_r;
        logic              in_fire_s;
        logic              out_fire_s;

        assign in_fire_s  = in_valid_i & ready_r;
        assign out_fire_s = valid_r & out_ready_i;

        // Handshake-driven next state and data moves; flush overrides them.
        always_comb begin
            state_fsm_s = state_r;
            main_fsm_s  = main_r;
            skid_fsm_s  = skid_r;
            case (state_r)
                PSR_EMPTY: begin
                    if (in_fire_s) begin
                        state_fsm_s = PSR_BUSY;
                        main_fsm_s  = in_data_i;
                    end else begin
                        state_fsm_s = PSR_EMPTY;
                    end
                end
                PSR_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        state_fsm_s = PSR_BUSY;
                        main_fsm_s  = in_data_i;
                    end else if (in_fire_s) begin
                        state_fsm_s = PSR_FULL;
                        skid_fsm_s  = in_data_i;
                    end else if (out_fire_s) begin
                        state_fsm_s = PSR_EMPTY;
                    end else begin
                        state_fsm_s = PSR_BUSY;
                    end
                end
                PSR_FULL: begin
                    if (out_fire_s) begin
                        state_fsm_s = PSR_BUSY;
                        main_fsm_s  = skid_r;
                    end else begin
                        state_fsm_s = PSR_FULL;
                    end
                end
                default: begin
                    state_fsm_s = PSR_EMPTY;
                end
            endcase

            state_nxt_s = state_fsm_s;
            main_nxt_s  = main_fsm_s;
            skid_nxt_s  = skid_fsm_s;
            if (flush_i) begin
                state_nxt_s = PSR_EMPTY;
                if (CLR_ON_FLUSH) begin
                    main_nxt_s = RST_VAL;
                    skid_nxt_s = RST_VAL;
                end else begin
                    main_nxt_s = main_r;
                    skid_nxt_s = skid_r;
                end
            end else begin
                state_nxt_s = state_fsm_s;
            end
        end

        // State, data and registered status outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= PSR_EMPTY;
                main_r  <= RST_VAL;
                skid_r  <= RST_VAL;
                ready_r <= 1'b1;
                valid_r <= 1'b0;
                occ_r   <= 2'd0;
            end else begin
                state_r <= state_nxt_s;
                main_r  <= main_nxt_s;
                skid_r  <= skid_nxt_s;
                ready_r <= (state_nxt_s != PSR_FULL);
                valid_r <= (state_nxt_s != PSR_EMPTY);
                occ_r   <= psr_occ(state_nxt_s);
            end
        end

        assign in_ready_o  = ready_r;
        assign out_valid_o = valid_r;
        assign out_data_o  = main_r;
        assign occ_o       = occ_r;

    end else begin : g_single
        psr_state_e        state_r, state_fsm_s, state_nxt_s;
        logic [DATA_W-1:0] main_r, main_fsm_s, main_nxt_s;
        logic              valid_r;
        logic [1:0]        occ_r;
        logic              ready_s;
        logic              in_fire_s;
        logic              out_fire_s;

        // Without a skid slot the register can only accept when it drains.
        assign ready_s    = out_ready_i | ~valid_r;
        assign in_fire_s  = in_valid_i & ready_s;
        assign out_fire_s = valid_r & out_ready_i;

        // Handshake-driven next state and data moves; flush overrides them.
        always_comb begin
            state_fsm_s = state_r;
            main_fsm_s  = main_r;
            case (state_r)
                PSR_EMPTY: begin
                    if (in_fire_s) begin
                        state_fsm_s = PSR_BUSY;
                        main_fsm_s  = in_data_i;
                    end else begin
                        state_fsm_s = PSR_EMPTY;
                    end
                end
                PSR_BUSY: begin
                    if (in_fire_s) begin
                        state_fsm_s = PSR_BUSY;
                        main_fsm_s  = in_data_i;
                    end else if (out_fire_s) begin
                        state_fsm_s = PSR_EMPTY;
                    end else begin
                        state_fsm_s = PSR_BUSY;
                    end
                end
                default: begin
                    state_fsm_s = PSR_EMPTY;
                end
            endcase

            state_nxt_s = state_fsm_s;
            main_nxt_s  = main_fsm_s;
            if (flush_i) begin
                state_nxt_s = PSR_EMPTY;
                if (CLR_ON_FLUSH) begin
                    main_nxt_s = RST_VAL;
                end else begin
                    main_nxt_s = main_r;
                end
            end else begin
                state_nxt_s = state_fsm_s;
            end
        end

        // State, data and registered status outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= PSR_EMPTY;
                main_r  <= RST_VAL;
                valid_r <= 1'b0;
                occ_r   <= 2'd0;
            end else begin
                state_r <= state_nxt_s;
                main_r  <= main_nxt_s;
                valid_r <= (state_nxt_s != PSR_EMPTY);
                occ_r   <= psr_occ(state_nxt_s);
            end
        end

        assign in_ready_o  = ready_s;
        assign out_valid_o = valid_r;
        assign out_data_o  = main_r;
        assign occ_o       = occ_r;
    end

endmodule
